store_buffer_ctrl: RTL and testbench

- Posted-write store buffer and sequencer between the MEM stage and the word-wide data memory.
- Accepts SB/SH/SW stores from the pipeline, lane-aligns each into a word address with a 32-bit data word and a 4-bit byte enable, queues it, and issues it to memory over a req/ack handshake.
- Back-pressures the pipeline when full and flags loads that hit a pending store's word, so the hazard unit can stall them.

---
 rtl/store_buffer_ctrl.sv | 112 +++++++++++
 tb/tb_store_buffer_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: posted-write store buffer that lane-aligns SB/SH/SW and issues them in order to data memory
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   st_valid/st_opcode/st_addr/st_data store from MEM stage; st_stall holds it while the queue is full
//   misalign_err                      one-cycle pulse after a dropped misaligned SH/SW
//   ld_check/ld_addr -> ld_hit        word-address hazard check against all queued stores
//   mem_req/mem_addr/mem_wdata/mem_be/mem_ack  word-wide write handshake to data memory
//   empty                             nothing queued and no request outstanding
module store_buffer_ctrl #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          st_valid,
   input  logic [5:0]    st_opcode,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_data,
   output logic          st_stall,
   output logic          misalign_err,
   input  logic          ld_check,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   output logic          empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
   logic [AW-3:0] addr_q [DEPTH];
   logic [AW-3:0] addr_d [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [31:0] data_d [DEPTH];
   logic [3:0] be_q [DEPTH];
   logic [3:0] be_d [DEPTH];
   logic misalign_q, misalign_d;
   logic is_sb, is_sh, is_store, aligned, push, pop, ld_unused;
   logic [3:0] st_be;
   logic [31:0] st_wdata;
   assign ld_unused = ^ld_addr[1:0];
   always_comb begin
      is_sb = st_opcode == OP_SB;
      is_sh = st_opcode == OP_SH;
      is_store = is_sb || is_sh || st_opcode == OP_SW;
      aligned = is_sb || (is_sh && !st_addr[0]) || st_addr[1:0] == 2'b00;
      st_be = is_sb ? 4'b0001 << st_addr[1:0] : is_sh ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_wdata = is_sb ? {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000}
               : is_sh ? (st_addr[1] ? {st_data[15:0], 16'h0} : {16'h0, st_data[15:0]})
               : st_data;
      st_stall = count_q == CW'(DEPTH);
      push = st_valid && is_store && aligned && !st_stall;
      pop = state_q == ISSUE && mem_ack;
      // a held (stalled) store is not judged until it is actually taken
      misalign_d = st_valid && is_store && !aligned && !st_stall;
      count_d = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      addr_d = addr_q;
      data_d = data_q;
      be_d = be_q;
      if (push) begin
         addr_d[wr_ptr_q] = st_addr[AW-1:2];
         data_d[wr_ptr_q] = st_wdata;
         be_d[wr_ptr_q] = st_be;
      end
      // post-update count covers both leaving IDLE on a push and staying in ISSUE after an ack
      state_d = count_d != '0 ? ISSUE : IDLE;
      mem_req = state_q == ISSUE;
      mem_addr = mem_req ? {addr_q[rd_ptr_q], 2'b00} : '0;
      mem_wdata = mem_req ? data_q[rd_ptr_q] : '0;
      mem_be = mem_req ? be_q[rd_ptr_q] : '0;
      misalign_err = misalign_q;
      empty = count_q == '0 && state_q == IDLE;
      ld_hit = 1'b0;
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         // entry i is live when its distance from the head is below count
         off = PW'(i) - rd_ptr_q;
         ld_hit = ld_hit | (ld_check && {1'b0, off} < count_q && addr_q[i] == ld_addr[AW-1:2]);
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         misalign_q <= misalign_d;
      end
   end
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      be_q <= be_d;
   end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb_store_buffer_ctrl: directed stimulus with a scoreboard of expected memory writes checked by a monitor
module tb_store_buffer_ctrl;
   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;
   logic clk = 0, reset_n = 0, st_valid = 0, ld_check = 0, mem_ack = 0;
   logic [5:0] st_opcode = '0;
   logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
   logic st_stall, misalign_err, ld_hit, mem_req, empty;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0] mem_be;
   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] be;} xfer_t;
   xfer_t sb[$];
   xfer_t e;
   int checks = 0, errors = 0;
   store_buffer_ctrl #(.DEPTH(4), .AW(32)) dut (
      .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_opcode(st_opcode),
      .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall), .misalign_err(misalign_err),
      .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .empty(empty)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", n, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      st_valid = 1;
      st_opcode = op;
      st_addr = a;
      st_data = d;
      tick();
      st_valid = 0;
   endtask
   task automatic wait_empty();
      for (int i = 0; i < 20 && !empty; i++) tick();
      chk("drain_empty", {31'b0, empty}, 1);
   endtask
   always @(negedge clk) begin
      if (reset_n && mem_req && mem_ack) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_xfer unexpected addr %h wdata %h be %b", mem_addr, mem_wdata, mem_be);
         end else begin
            e = sb.pop_front();
            chk("mem_addr", mem_addr, e.a);
            chk("mem_wdata", mem_wdata, e.d);
            chk("mem_be", {28'b0, mem_be}, {28'b0, e.be});
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) tick();
      reset_n = 1;
      tick();
      ld_check = 1;
      ld_addr = 32'h0;
      #1;
      chk("rst_req", {31'b0, mem_req}, 0);
      chk("rst_empty", {31'b0, empty}, 1);
      chk("rst_stall", {31'b0, st_stall}, 0);
      chk("rst_ld_hit", {31'b0, ld_hit}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_misalign", {31'b0, misalign_err}, 0);
      ld_check = 0;
      mem_ack = 1;
      sb.push_back('{32'h100, 32'hA500_0000, 4'b1000});
      store(OP_SB, 32'h103, 32'h0000_00A5);
      #1;
      chk("sb_req", {31'b0, mem_req}, 1);
      tick();
      chk("sb_empty", {31'b0, empty}, 1);
      sb.push_back('{32'h200, 32'hBEEF_0000, 4'b1100});
      sb.push_back('{32'h204, 32'hCAFE_F00D, 4'b1111});
      st_valid = 1;
      st_opcode = OP_SH;
      st_addr = 32'h202;
      st_data = 32'h1234_BEEF;
      tick();
      #1;
      chk("sh_req", {31'b0, mem_req}, 1);
      chk("sh_be", {28'b0, mem_be}, 32'hC);
      st_opcode = OP_SW;
      st_addr = 32'h204;
      st_data = 32'hCAFE_F00D;
      tick();
      st_valid = 0;
      #1;
      chk("sw_req", {31'b0, mem_req}, 1);
      chk("sw_be", {28'b0, mem_be}, 32'hF);
      tick();
      chk("shsw_empty", {31'b0, empty}, 1);
      mem_ack = 0;
      for (int k = 0; k < 4; k++) begin
         st_valid = 1;
         st_opcode = OP_SW;
         st_addr = 32'h500 + 32'(4 * k);
         st_data = 32'h1111_0000 + 32'(k);
         #1;
         chk("fill_stall", {31'b0, st_stall}, 0);
         sb.push_back('{32'h500 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111});
         tick();
      end
      st_addr = 32'h510;
      st_data = 32'h2222_0005;
      #1;
      chk("full_stall", {31'b0, st_stall}, 1);
      tick();
      #1;
      chk("held_stall", {31'b0, st_stall}, 1);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      #1;
      chk("unstall", {31'b0, st_stall}, 0);
      sb.push_back('{32'h510, 32'h2222_0005, 4'b1111});
      tick();
      st_valid = 0;
      #1;
      chk("refull_stall", {31'b0, st_stall}, 1);
      mem_ack = 1;
      wait_empty();
      store(OP_SH, 32'h301, 32'h0000_5555);
      chk("sh_mis_err", {31'b0, misalign_err}, 1);
      chk("sh_mis_empty", {31'b0, empty}, 1);
      tick();
      chk("sh_mis_pulse", {31'b0, misalign_err}, 0);
      store(OP_SW, 32'h302, 32'h6666_7777);
      chk("sw_mis_err", {31'b0, misalign_err}, 1);
      chk("sw_mis_empty", {31'b0, empty}, 1);
      tick();
      chk("sw_mis_pulse", {31'b0, misalign_err}, 0);
      mem_ack = 0;
      store(OP_SW, 32'h400, 32'hDEAD_BEEF);
      ld_check = 1;
      ld_addr = 32'h402;
      #1;
      chk("ld_hit_same", {31'b0, ld_hit}, 1);
      ld_addr = 32'h404;
      #1;
      chk("ld_hit_next", {31'b0, ld_hit}, 0);
      ld_check = 0;
      ld_addr = 32'h400;
      #1;
      chk("ld_hit_nochk", {31'b0, ld_hit}, 0);
      chk("pend_req", {31'b0, mem_req}, 1);
      reset_n = 0;
      #1;
      chk("arst_req", {31'b0, mem_req}, 0);
      mem_ack = 1;
      repeat (2) tick();
      reset_n = 1;
      tick();
      ld_check = 1;
      #1;
      chk("post_empty", {31'b0, empty}, 1);
      chk("post_ld_hit", {31'b0, ld_hit}, 0);
      chk("post_req", {31'b0, mem_req}, 0);
      tick();
      chk("late_ack_req", {31'b0, mem_req}, 0);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
